// File: rtl/csa_resolver.sv
// csa_resolver: chunked multi-cycle carry-propagate adder that resolves a
// carry-save (sum, carry) pair into the binary value sum + 2*carry.
// Chunk bits are resolved per cycle with a registered ripple carry.
// Optional feature macro: CSA_RESOLVER_ZERO_SKIP_EN. When defined, the block
// finishes early once every remaining captured bit and the running carry
// are zero.
module csa_resolver #(
    parameter int Width = 8,
    parameter int Chunk = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [Width-1:0] sum,
    input  logic [Width-1:0] carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width+1:0] result
);

    localparam int N    = Width / Chunk;
    localparam int CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q;
    logic [Width-1:0] sum_q;
    logic [Width-1:0] carry_q;
    logic [Width+1:0] result_q;
    logic [CntW-1:0]  cnt_q;
    logic             rcarry_q;
    logic             inReady_q;
    logic             outValid_q;

    logic [Width-1:0] bVec;
    logic [Chunk-1:0] sumSlice;
    logic [Chunk-1:0] bSlice;
    logic [Chunk:0]   sliceTotal_d;
    logic             rcarry_d;
    logic             lastSlice;
    logic [1:0]       topBits_d;
    logic             finish_d;
    int               sliceBase;

`ifdef CSA_RESOLVER_ZERO_SKIP_EN
    logic             restZero;
    int               restBase;
`endif

    // Slice adder: resolves the current chunk and decides whether this is the final BUSY cycle.
    always_comb begin
        sliceBase    = int'(cnt_q) * Chunk;
        bVec         = carry_q << 1;
        sumSlice     = sum_q[sliceBase +: Chunk];
        bSlice       = bVec[sliceBase +: Chunk];
        sliceTotal_d = {1'b0, sumSlice} + {1'b0, bSlice} + {{Chunk{1'b0}}, rcarry_q};
        rcarry_d     = sliceTotal_d[Chunk];
        lastSlice    = (cnt_q == CntW'(N - 1));
        topBits_d    = {1'b0, carry_q[Width-1]} + {1'b0, rcarry_d};
        finish_d     = lastSlice;
`ifdef CSA_RESOLVER_ZERO_SKIP_EN
        // The carry bit just below the next slice boundary feeds that slice through the shift.
        restBase = sliceBase + Chunk;
        restZero = ((sum_q >> restBase) == '0) && ((carry_q >> (restBase - 1)) == '0) && !rcarry_d;
        if (restZero) begin
            finish_d = 1'b1;
        end
`endif
    end

    // Control FSM with registered handshake outputs; the result register fills one chunk per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inReady_q  <= 1'b1;
            outValid_q <= 1'b0;
            result_q   <= '0;
            cnt_q      <= '0;
            rcarry_q   <= 1'b0;
            sum_q      <= '0;
            carry_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && inReady_q) begin
                        sum_q     <= sum;
                        carry_q   <= carry;
                        result_q  <= '0;
                        rcarry_q  <= 1'b0;
                        cnt_q     <= '0;
                        inReady_q <= 1'b0;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    result_q[sliceBase +: Chunk] <= sliceTotal_d[Chunk-1:0];
                    rcarry_q <= rcarry_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (lastSlice) begin
                        result_q[Width+1:Width] <= topBits_d;
                    end
                    if (finish_d) begin
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        inReady_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    outValid_q <= 1'b0;
                    inReady_q  <= 1'b1;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign result    = result_q;

endmodule
